register_file_2r1w: RTL and testbench

// - 8 x 16-bit general-purpose register file for the 16-bit processor; the

---
 rtl/register_file_2r1w_if.sv | 39 +++
 rtl/register_file_2r1w.sv | 82 ++++++++
 tb/tb_register_file_2r1w.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/register_file_2r1w_if.sv
// Bus interface for register_file_2r1w.
//
// Bundles the write port, the read-request handshake and the registered read
// data into one connection. clk and reset stay plain ports on the modules.
//
// Signals (directions given from the master, i.e. the ALU operand stage):
//   en         out  write enable
//   wr_addr    out  write address
//   D          out  write data
//   rd_req     out  read request; samples rd_addr_a / rd_addr_b
//   rd_addr_a  out  read address, port A
//   rd_addr_b  out  read address, port B
//   Q_a        in   read data, port A
//   Q_b        in   read data, port B
//   rd_valid   in   Q_a / Q_b hold the data for the previous rd_req
interface register_file_2r1w_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] D;
    logic             rd_req;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] Q_a;
    logic [WIDTH-1:0] Q_b;
    logic             rd_valid;

    modport master (
        output en, wr_addr, D, rd_req, rd_addr_a, rd_addr_b,
        input  Q_a, Q_b, rd_valid
    );

    modport slave (
        input  en, wr_addr, D, rd_req, rd_addr_a, rd_addr_b,
        output Q_a, Q_b, rd_valid
    );
endinterface

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 8 x 16-bit general-purpose register file.
//
// One synchronous write port and two registered read ports (A, B) sharing a
// request/valid handshake with one cycle of latency. R0 is hardwired to zero:
// writes to it are dropped and it always reads 0. There is no backpressure;
// the consumer takes Q_a / Q_b on the cycle rd_valid is high.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high; clears registers, Q_a/Q_b, rd_valid
//   bus    slave modport of register_file_2r1w_if (write port, read request,
//          read data and rd_valid)
//
// Configuration macro:
//   REGFILE_BYPASS_EN  defined   -> write-first: a read of the register being
//                                   written on the same edge returns D.
//                      undefined -> read-first: that read returns the old value.
module register_file_2r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    register_file_2r1w_if.slave    bus
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] q_a_r;
    logic [WIDTH-1:0] q_b_r;
    logic             rd_valid_r;

    logic             wr_hit;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Entry 0 is never written, so after reset it stays zero and R0 reads 0.
    assign wr_hit = bus.en && (bus.wr_addr != AW'(0));

    // Read operands presented to the output registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        rd_a = regs[bus.rd_addr_a];
        rd_b = regs[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Write-first: forward the incoming write data over the stale entry.
        if (wr_hit && (bus.wr_addr == bus.rd_addr_a)) rd_a = bus.D;
        if (wr_hit && (bus.wr_addr == bus.rd_addr_b)) rd_b = bus.D;
`else
        // Read-first: the array value sampled on this edge is the pre-write
        // contents; the new value appears to reads on later cycles.
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is cleared on reset here because the register file must read back zero after reset; a plain RAM would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            q_a_r      <= '0;
            q_b_r      <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so the array read above sees the pre-edge contents.
            if (wr_hit) begin
                regs[bus.wr_addr] <= bus.D;
            end
            // Q holds its last value when no request is made.
            if (bus.rd_req) begin
                q_a_r <= rd_a;
                q_b_r <= rd_b;
            end
            rd_valid_r <= bus.rd_req;
        end
    end

    assign bus.Q_a      = q_a_r;
    assign bus.Q_b      = q_b_r;
    assign bus.rd_valid = rd_valid_r;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking testbench for register_file_2r1w.
//
// Every clock cycle is driven through step(), which computes the expected
// post-edge outputs from an array model of the register file and pushes them
// into a scoreboard queue. An independent monitor pops one entry per cycle on
// the falling edge and compares rd_valid, Q_a and Q_b.
module tb_register_file_2r1w;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] qa;
        logic [WIDTH-1:0] qb;
    } exp_t;

    logic clk;
    logic reset;

    register_file_2r1w_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    register_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    exp_t             sb [$];
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, req);
        end
    endtask

    // Value a read of addr should capture, given the write on the same edge.
    function automatic logic [WIDTH-1:0] ref_read(input logic [AW-1:0] addr,
                                                  input logic en,
                                                  input logic [AW-1:0] wr,
                                                  input logic [WIDTH-1:0] d);
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (en && wr == addr) return d;
`endif
        return model[addr];
    endfunction

    task automatic step(input logic rst, input logic en, input logic [AW-1:0] wr,
                        input logic [WIDTH-1:0] d, input logic req,
                        input logic [AW-1:0] a, input logic [AW-1:0] b);
        exp_t e;
        reset         = rst;
        bus.en        = en;
        bus.wr_addr   = wr;
        bus.D         = d;
        bus.rd_req    = req;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        if (rst) begin
            hold_a = '0;
            hold_b = '0;
            e.v    = 1'b0;
        end else begin
            if (req) begin
                hold_a = ref_read(a, en, wr, d);
                hold_b = ref_read(b, en, wr, d);
            end
            e.v = req;
        end
        e.qa = hold_a;
        e.qb = hold_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (en && wr != 0) begin
            model[wr] = d;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic wr_reg(input logic [AW-1:0] wr, input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, wr, d, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, a, b);
    endtask

    // Monitor: one scoreboard entry per clock, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rd_valid", {15'd0, bus.rd_valid}, {15'd0, e.v});
            check("Q_a", bus.Q_a, e.qa);
            check("Q_b", bus.Q_b, e.qb);
        end
    end

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rw;
        hold_a = '0;
        hold_b = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset for two cycles, then read every address.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            ra = AW'(i);
            rb = AW'(i + 4);
            rd(ra, rb);
        end
        idle();

        // Basic write then read.
        wr_reg(3'd3, 16'h0003);
        wr_reg(3'd5, 16'h000D);
        rd(3'd3, 3'd5);
        idle();

        // Write to R0 ignored; en=0 blocks the write.
        wr_reg(3'd0, 16'hBEEF);
        step(1'b0, 1'b0, 3'd2, 16'h0002, 1'b0, 3'd0, 3'd0);
        rd(3'd0, 3'd2);
        idle();

        // Same-edge write/read collision, then R0 write with read of R0.
        wr_reg(3'd4, 16'h1111);
        step(1'b0, 1'b1, 3'd4, 16'h2222, 1'b1, 3'd4, 3'd1);
        rd(3'd4, 3'd4);
        step(1'b0, 1'b1, 3'd0, 16'h5A5A, 1'b1, 3'd0, 3'd0);
        idle();

        // Streaming reads on 1..4, then hold after rd_req drops.
        wr_reg(3'd1, 16'hA001);
        wr_reg(3'd2, 16'hA002);
        wr_reg(3'd3, 16'hA003);
        wr_reg(3'd4, 16'hA004);
        for (int i = 1; i <= 4; i++) begin
            ra = AW'(i);
            rb = AW'(5 - i);
            rd(ra, rb);
        end
        idle();
        idle();

        // Request followed directly by reset, then everything reads zero.
        wr_reg(3'd7, 16'h7777);
        rd(3'd7, 3'd1);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd7);
        for (int i = 0; i < 4; i++) begin
            ra = AW'(i);
            rb = AW'(i + 4);
            rd(ra, rb);
        end
        idle();

        // Randomized traffic including occasional resets and collisions.
        for (int n = 0; n < 400; n++) begin
            rw = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? rw : AW'($urandom_range(0, DEPTH - 1));
            rb = ($urandom_range(0, 3) == 0) ? rw : AW'($urandom_range(0, DEPTH - 1));
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), rw,
                 16'($urandom), ($urandom_range(0, 3) != 0), ra, rb);
        end
        idle();

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
